// File: rtl/multiphase_clock_controller.sv
// Multiphase clock controller: NPHASE overlapping phase clocks from a prescaled step
// counter, with free-run, finish-on-stop, single-step and N-cycle burst modes.
module multiphase_clock_controller #(
    parameter int NPHASE     = 4,
    parameter int HIGH_STEPS = 2,
    parameter int PRESCALE   = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pause,
    input  logic              run_en,
    input  logic              step_req,
    input  logic              burst_start,
    input  logic [CNT_W-1:0]  burst_len,
    output logic [NPHASE-1:0] phase,
    output logic              cycle_done,
    output logic              busy,
    output logic [31:0]       cycle_count
);

    localparam int SW = $clog2(NPHASE);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;
    localparam logic [1:0] BURST  = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [SW-1:0]    step, step_nxt;
    logic [PW-1:0]    pcnt, pcnt_nxt;
    logic [CNT_W-1:0] remaining, remaining_nxt;
    logic             advancing, tick, wrap;

    function automatic logic [NPHASE-1:0] decode(input logic [SW-1:0] s);
        for (int k = 0; k < NPHASE; k++)
            decode[k] = (((int'(s) - k + NPHASE) % NPHASE) < HIGH_STEPS);
    endfunction

    assign busy      = (state != IDLE);
    assign advancing = busy && !pause;
    assign tick      = advancing && (pcnt == PW'(PRESCALE - 1));
    assign wrap      = tick && (step == SW'(NPHASE - 1));

    always_comb begin
        step_nxt = step;
        if (tick)
            step_nxt = wrap ? '0 : step + SW'(1);
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        if (!pause) begin
            case (state)
                IDLE: begin
                    if (run_en) begin
                        state_nxt = RUN;
                    end else if (burst_start && burst_len != '0) begin
                        state_nxt     = BURST;
                        remaining_nxt = burst_len;
                    end else if (step_req) begin
                        state_nxt     = BURST;
                        remaining_nxt = CNT_W'(1);
                    end
                end
                // Stopping exactly on a wrap edge needs no extra cycle to finish.
                RUN:    if (!run_en) state_nxt = wrap ? IDLE : FINISH;
                FINISH: begin
                    if (run_en)    state_nxt = RUN;
                    else if (wrap) state_nxt = IDLE;
                end
                BURST: begin
                    if (run_en) begin
                        state_nxt     = RUN;
                        remaining_nxt = '0;
                    end else if (wrap) begin
                        remaining_nxt = remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        pcnt_nxt = pcnt;
        if (state_nxt == IDLE)
            pcnt_nxt = '0;
        else if (advancing)
            pcnt_nxt = tick ? '0 : pcnt + PW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            step        <= '0;
            pcnt        <= '0;
            remaining   <= '0;
            cycle_done  <= 1'b0;
            cycle_count <= '0;
            phase       <= decode('0);
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            pcnt       <= pcnt_nxt;
            remaining  <= remaining_nxt;
            cycle_done <= wrap;
            phase      <= decode(step_nxt);
            if (wrap) cycle_count <= cycle_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_multiphase_clock_controller.sv
// Self-checking bench: a 4-phase/prescale-2 instance against a rotating-pattern model,
// plus a 6-phase/prescale-1 instance checked against the phase formula.
module tb_multiphase_clock_controller;

    localparam int N = 4, H = 2, P = 2, CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          pause, run_en, step_req, burst_start;
    logic [CW-1:0] burst_len;
    logic [N-1:0]  phase;
    logic          cycle_done, busy;
    logic [31:0]   cycle_count;

    logic          run_en6, pause6, step_req6, burst_start6;
    logic [CW-1:0] burst_len6;
    logic [5:0]    phase6;
    logic          cycle_done6, busy6;
    logic [31:0]   cycle_count6;

    int n_checks = 0;
    int n_fail   = 0;

    multiphase_clock_controller #(.NPHASE(N), .HIGH_STEPS(H), .PRESCALE(P), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pause(pause), .run_en(run_en), .step_req(step_req),
        .burst_start(burst_start), .burst_len(burst_len), .phase(phase),
        .cycle_done(cycle_done), .busy(busy), .cycle_count(cycle_count));

    multiphase_clock_controller #(.NPHASE(6), .HIGH_STEPS(3), .PRESCALE(1), .CNT_W(CW)) dut6 (
        .clk(clk), .rst(rst), .pause(pause6), .run_en(run_en6), .step_req(step_req6),
        .burst_start(burst_start6), .burst_len(burst_len6), .phase(phase6),
        .cycle_done(cycle_done6), .busy(busy6), .cycle_count(cycle_count6));

    // Reference model: a rotating phase pattern plus clk-per-step and cycle bookkeeping.
    typedef enum {M_IDLE, M_RUN, M_FIN, M_BURST} mode_t;
    mode_t       m_mode;
    int          m_step, m_pc, m_rem;
    logic [N-1:0] m_pat;
    logic        m_done, m_wrap;
    logic [31:0] m_count;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_step = 0; m_pc = 0; m_rem = 0;
            m_pat = 4'b1001; m_done = 0; m_count = 0;
        end else begin
            m_done = 0;
            m_wrap = 0;
            if (!pause) begin
                if (m_mode != M_IDLE) begin
                    m_pc++;
                    if (m_pc == P) begin
                        m_pc   = 0;
                        m_step = (m_step + 1) % N;
                        m_pat  = {m_pat[N-2:0], m_pat[N-1]};
                        if (m_step == 0) begin
                            m_wrap = 1; m_done = 1; m_count++;
                        end
                    end
                end
                case (m_mode)
                    M_IDLE: begin
                        if (run_en) m_mode = M_RUN;
                        else if (burst_start && burst_len != 0) begin m_mode = M_BURST; m_rem = burst_len; end
                        else if (step_req) begin m_mode = M_BURST; m_rem = 1; end
                    end
                    M_RUN: if (!run_en) m_mode = m_wrap ? M_IDLE : M_FIN;
                    M_FIN: begin
                        if (run_en) m_mode = M_RUN;
                        else if (m_wrap) m_mode = M_IDLE;
                    end
                    M_BURST: begin
                        if (run_en) begin m_mode = M_RUN; m_rem = 0; end
                        else if (m_wrap) begin
                            m_rem--;
                            if (m_rem == 0) m_mode = M_IDLE;
                        end
                    end
                endcase
                if (m_mode == M_IDLE) m_pc = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pause = 0; run_en = 0; step_req = 0; burst_start = 0; burst_len = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({phase, cycle_done, busy, cycle_count} !== {4'b1001, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset: phase=%b done=%b busy=%b cnt=%0d, expected 1001/0/0/0",
                     phase, cycle_done, busy, cycle_count);
        end
        n_checks++;
        if ({phase6, busy6, cycle_count6} !== {6'b110001, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset6: phase=%b busy=%b cnt=%0d, expected 110001/0/0", phase6, busy6, cycle_count6);
        end
    endtask

    task automatic test_free_run();
        int pulses = 0, last = -1, spacing_bad = 0;
        do_reset();
        run_en = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            n_checks++;
            if ({phase, cycle_done, busy, cycle_count} !== {m_pat, m_done, (m_mode != M_IDLE), m_count}) begin
                n_fail++;
                $display("FAIL free_run cyc %0d: got %b/%b/%b/%0d exp %b/%b/%b/%0d", i,
                         phase, cycle_done, busy, cycle_count, m_pat, m_done, (m_mode != M_IDLE), m_count);
            end
            if (cycle_done) begin
                if (last >= 0 && i - last != 8) spacing_bad++;
                last = i; pulses++;
            end
        end
        n_checks++;
        if (pulses != 4 || spacing_bad != 0 || cycle_count !== 32'd4) begin
            n_fail++;
            $display("FAIL free_run_count: pulses=%0d bad_spacing=%0d cnt=%0d, expected 4/0/4",
                     pulses, spacing_bad, cycle_count);
        end
    endtask

    // Continues from free-run, now at step 1: dropping run_en must finish steps 2 and 3.
    task automatic test_finish();
        run_en = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({phase, cycle_done, busy, cycle_count} !== {m_pat, m_done, (m_mode != M_IDLE), m_count}) begin
                n_fail++;
                $display("FAIL finish cyc %0d: got %b/%b/%b/%0d exp %b/%b/%b/%0d", i,
                         phase, cycle_done, busy, cycle_count, m_pat, m_done, (m_mode != M_IDLE), m_count);
            end
        end
        n_checks++;
        if ({phase, busy, cycle_count} !== {4'b1001, 1'b0, 32'd5}) begin
            n_fail++;
            $display("FAIL finish_end: phase=%b busy=%b cnt=%0d, expected 1001/0/5", phase, busy, cycle_count);
        end
    endtask

    task automatic test_single_step();
        int pulses = 0, changes = 0;
        logic [N-1:0] prev;
        do_reset();
        prev = phase;
        step_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            step_req = (i == 3);
            n_checks++;
            if ({phase, cycle_done, busy, cycle_count} !== {m_pat, m_done, (m_mode != M_IDLE), m_count}) begin
                n_fail++;
                $display("FAIL single_step cyc %0d: got %b/%b/%b/%0d exp %b/%b/%b/%0d", i,
                         phase, cycle_done, busy, cycle_count, m_pat, m_done, (m_mode != M_IDLE), m_count);
            end
            if (phase !== prev) changes++;
            prev = phase;
            if (cycle_done) pulses++;
        end
        n_checks++;
        if (pulses != 1 || changes != 4 || {phase, busy, cycle_count} !== {4'b1001, 1'b0, 32'd1}) begin
            n_fail++;
            $display("FAIL single_step_end: pulses=%0d changes=%0d phase=%b busy=%b cnt=%0d, expected 1/4/1001/0/1",
                     pulses, changes, phase, busy, cycle_count);
        end
    endtask

    task automatic test_burst();
        int pulses = 0, busy_bad = 0;
        do_reset();
        burst_len = 16'd3; burst_start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            burst_start = 1'b0;
            n_checks++;
            if ({phase, cycle_done, busy, cycle_count} !== {m_pat, m_done, (m_mode != M_IDLE), m_count}) begin
                n_fail++;
                $display("FAIL burst cyc %0d: got %b/%b/%b/%0d exp %b/%b/%b/%0d", i,
                         phase, cycle_done, busy, cycle_count, m_pat, m_done, (m_mode != M_IDLE), m_count);
            end
            if (cycle_done) begin
                pulses++;
                if (busy !== (pulses < 3)) busy_bad++;
            end
        end
        n_checks++;
        if (pulses != 3 || busy_bad != 0 || cycle_count !== 32'd3) begin
            n_fail++;
            $display("FAIL burst_end: pulses=%0d busy_edge_bad=%0d cnt=%0d, expected 3/0/3", pulses, busy_bad, cycle_count);
        end
        burst_len = '0; burst_start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            burst_start = 1'b0;
            n_checks++;
            if (busy !== 1'b0 || phase !== 4'b1001) begin
                n_fail++;
                $display("FAIL burst_len0 cyc %0d: busy=%b phase=%b, expected 0/1001", i, busy, phase);
            end
        end
    endtask

    task automatic test_pause();
        int guard = 0, pulses = 0;
        do_reset();
        burst_len = 16'd2; burst_start = 1'b1;
        @(negedge clk);
        burst_start = 1'b0;
        while (!(m_step == 2 && m_pc == 0) && guard < 40) begin
            @(negedge clk); guard++;
        end
        n_checks++;
        if (guard >= 40) begin
            n_fail++;
            $display("FAIL pause_reach: step 2 not reached in 40 clk, model step=%0d", m_step);
        end
        pause = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (phase !== 4'b0110 || cycle_done !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL pause_hold cyc %0d: phase=%b done=%b busy=%b, expected 0110/0/1", i, phase, cycle_done, busy);
            end
        end
        pause = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({phase, cycle_done, busy, cycle_count} !== {m_pat, m_done, (m_mode != M_IDLE), m_count}) begin
                n_fail++;
                $display("FAIL pause_resume cyc %0d: got %b/%b/%b/%0d exp %b/%b/%b/%0d", i,
                         phase, cycle_done, busy, cycle_count, m_pat, m_done, (m_mode != M_IDLE), m_count);
            end
            if (cycle_done) pulses++;
        end
        n_checks++;
        if (busy !== 1'b0 || cycle_count !== 32'd2) begin
            n_fail++;
            $display("FAIL pause_total: busy=%b cnt=%0d, expected 0/2", busy, cycle_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        burst_len = 16'd5; burst_start = 1'b1;
        run_en6 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            burst_start = 1'b0;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({phase, cycle_done, busy, cycle_count} !== {4'b1001, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL async_reset: phase=%b done=%b busy=%b cnt=%0d, expected 1001/0/0/0",
                     phase, cycle_done, busy, cycle_count);
        end
        n_checks++;
        if ({phase6, busy6, cycle_count6} !== {6'b110001, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL async_reset6: phase=%b busy=%b cnt=%0d, expected 110001/0/0", phase6, busy6, cycle_count6);
        end
        run_en6 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        burst_len = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            n_checks++;
            if ({phase, cycle_done, busy, cycle_count} !== {m_pat, m_done, (m_mode != M_IDLE), m_count}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b/%b/%b/%0d exp %b/%b/%b/%0d", i,
                         phase, cycle_done, busy, cycle_count, m_pat, m_done, (m_mode != M_IDLE), m_count);
            end
            if ($urandom_range(0, 24) == 0) run_en = ~run_en;
            if ($urandom_range(0, 9) == 0)  pause  = ~pause;
            step_req    = ($urandom_range(0, 7) == 0);
            burst_start = ($urandom_range(0, 9) == 0);
            burst_len   = CW'($urandom_range(0, 3));
        end
        run_en = 0; pause = 0; step_req = 0; burst_start = 0;
    endtask

    task automatic test_nphase6();
        int s;
        logic [5:0] exp_phase;
        do_reset();
        run_en6 = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            s = (j - 1) % 6;
            for (int k = 0; k < 6; k++) exp_phase[k] = ((((s - k) % 6) + 6) % 6) < 3;
            n_checks++;
            if ({phase6, cycle_done6, busy6, cycle_count6} !==
                {exp_phase, (j > 1 && s == 0), 1'b1, 32'((j - 1) / 6)}) begin
                n_fail++;
                $display("FAIL nphase6 cyc %0d: got %b/%b/%b/%0d exp %b/%b/1/%0d", j,
                         phase6, cycle_done6, busy6, cycle_count6, exp_phase, (j > 1 && s == 0), (j - 1) / 6);
            end
        end
        run_en6 = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (busy6 !== 1'b0 || phase6 !== 6'b110001) begin
            n_fail++;
            $display("FAIL nphase6_stop: busy=%b phase=%b, expected 0/110001", busy6, phase6);
        end
    endtask

    initial begin
        rst = 1'b1;
        pause = 0; run_en = 0; step_req = 0; burst_start = 0; burst_len = '0;
        run_en6 = 0; pause6 = 0; step_req6 = 0; burst_start6 = 0; burst_len6 = '0;
        test_reset();
        test_free_run();
        test_finish();
        test_single_step();
        test_burst();
        test_pause();
        test_async_reset();
        test_random();
        test_nphase6();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
